// File: rtl/ilog_calc.sv
// rtl/ilog_calc.sv - sequential floor(log_B(V)) unit with exactness flag and valid/ready handshakes
// Optional macro ILOG_POW2_FAST_EN: base-2 requests resolve at the accepting edge via a priority encoder.
module ilog_calc #(
  parameter int WIDTH = 32,
  localparam int LOGW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_base,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGW-1:0]  out_log,
  output logic             out_exact,
  output logic             out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [WIDTH-1:0]   r_base;
  logic [WIDTH-1:0]   r_value;
  logic [WIDTH-1:0]   r_acc;
  logic [LOGW-1:0]    r_k;
  logic [LOGW-1:0]    r_log;
  logic               r_exact;
  logic               r_err;

  logic               w_accept;
  logic               w_illegal;
  logic               w_fast;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_le;

  // Handshake outputs are pure decodes of the state register, so in_ready never depends on out_ready.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_log   = r_log;
  assign out_exact = r_exact;
  assign out_err   = r_err;

  assign w_accept  = in_valid && in_ready;
  assign w_illegal = (in_base < WIDTH'(2)) || (in_value == '0);

  // Double-width product: acc <= V < 2^WIDTH and B < 2^WIDTH, so acc*B can never wrap.
  assign w_prod = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_base};
  assign w_le   = (w_prod <= {{WIDTH{1'b0}}, r_value});

`ifdef ILOG_POW2_FAST_EN
  logic [LOGW-1:0] w_msb;
  logic            w_pow2;

  // Priority encoder: highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_value[i]) w_msb = i[LOGW-1:0];
    end
  end

  assign w_pow2 = ((in_value & (in_value - WIDTH'(1))) == '0);
  assign w_fast = (in_base == WIDTH'(2));
`else
  assign w_fast = 1'b0;
`endif

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode: illegal (and fast base-2) requests skip RUN entirely.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal || w_fast) w_state_next = S_DONE;
          else                     w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_le) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, one multiply-compare per RUN cycle, results frozen outside updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base  <= '0;
      r_value <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_log   <= '0;
      r_exact <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base  <= in_base;
            r_value <= in_value;
            r_acc   <= WIDTH'(1);
            r_k     <= '0;
            if (w_illegal) begin
              r_log   <= '0;
              r_exact <= 1'b0;
              r_err   <= 1'b1;
            end
`ifdef ILOG_POW2_FAST_EN
            else if (w_fast) begin
              r_log   <= w_msb;
              r_exact <= w_pow2;
              r_err   <= 1'b0;
            end
`endif
          end
        end
        S_RUN: begin
          if (w_le) begin
            r_acc <= w_prod[WIDTH-1:0];
            r_k   <= r_k + LOGW'(1);
          end else begin
            r_log   <= r_k;
            r_exact <= (r_acc == r_value);
            r_err   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ilog_calc.sv
// tb/tb_ilog_calc.sv - scoreboard bench for ilog_calc against a reference integer-log model
module tb_ilog_calc;

  localparam int WIDTH = 32;
  localparam int LOGW  = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_base;
  logic [WIDTH-1:0] in_value;
  logic             out_valid;
  logic             out_ready;
  logic [LOGW-1:0]  out_log;
  logic             out_exact;
  logic             out_err;

  typedef struct {
    logic [63:0] log_v;
    logic        exact;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests;
  int   n_fail;

  ilog_calc #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_log   (out_log),
    .out_exact (out_exact),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the pow-inverse: repeated multiplication in 64 bits.
  function automatic exp_t model(input logic [31:0] b, input logic [31:0] v);
    exp_t        e;
    logic [63:0] acc;
    logic [63:0] l;
    e.log_v = '0;
    e.exact = 1'b0;
    e.err   = 1'b0;
    e.lat   = 0;
    if (b < 2 || v == 0) begin
      e.err = 1'b1;
    end else begin
      acc = 64'd1;
      l   = 64'd0;
      while (acc * {32'd0, b} <= {32'd0, v}) begin
        acc = acc * {32'd0, b};
        l   = l + 1;
      end
      e.log_v = l;
      e.exact = (acc == {32'd0, v});
      e.lat   = int'(l) + 1;
`ifdef ILOG_POW2_FAST_EN
      if (b == 2) e.lat = 0;
`endif
    end
    return e;
  endfunction

  task automatic run_req(input logic [31:0] b, input logic [31:0] v, input int hold);
    exp_t e;
    int   n;
    logic [LOGW-1:0] held_log;
    logic            held_exact;
    logic            held_err;
    q_exp.push_back(model(b, v));
    out_ready = (hold == 0);
    in_base   = b;
    in_value  = v;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    e = q_exp.pop_front();
    check($sformatf("latency b=%0d v=%0h", b, v), n, e.lat);
    check("out_valid", out_valid, 1);
    check($sformatf("log b=%0d v=%0h", b, v), {59'd0, out_log}, e.log_v);
    check($sformatf("exact b=%0d v=%0h", b, v), out_exact, e.exact);
    check($sformatf("err b=%0d v=%0h", b, v), out_err, e.err);
    if (hold > 0) begin
      held_log   = out_log;
      held_exact = out_exact;
      held_err   = out_err;
      in_base    = 32'd2;
      in_value   = 32'd4;
      in_valid   = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_log", {59'd0, out_log}, {59'd0, held_log});
        check("hold_exact", out_exact, held_exact);
        check("hold_err", out_err, held_err);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_base   = '0;
    in_value  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_log", {59'd0, out_log}, 0);
    check("rst_exact", out_exact, 0);
    check("rst_err", out_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(32'd2, 32'd8, 0);
    run_req(32'd3, 32'd100, 0);
    run_req(32'd10, 32'd1000, 0);
    run_req(32'd1, 32'd5, 0);
    run_req(32'd7, 32'd0, 0);
    run_req(32'd0, 32'd9, 0);
    run_req(32'd2, 32'hFFFF_FFFF, 0);
    run_req(32'd5, 32'd1, 0);
    run_req(32'd9, 32'd4, 0);
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_req(32'd2, 32'h8000_0000, 0);
    run_req(32'd3, 32'd100, 10);
    run_req(32'd6, 32'd216, 0);
    for (int i = 0; i < 8; i++) begin
      run_req($urandom_range(2, 20), $urandom, 0);
    end

    // Reset mid-computation, then a fresh request.
    q_exp.push_back(model(32'd2, 32'h0010_0000));
    out_ready = 1'b0;
    in_base   = 32'd2;
    in_value  = 32'h0010_0000;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`ifndef ILOG_POW2_FAST_EN
    check("midrun_valid", out_valid, 0);
    check("midrun_in_ready", in_ready, 0);
`endif
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_log", {59'd0, out_log}, 0);
    void'(q_exp.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(32'd4, 32'd64, 0);

    check("queue_empty", q_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
